// File: rtl/pic_inta_sequencer.sv
// Interrupt acknowledge sequencer: qualifies the PIC INT line, issues the
// two-pulse INTA cycle, captures the vector on pulse 2 and hands it to the
// CPU over valid/ready.
module pic_inta_sequencer #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_in,
  input  logic       ack_en,
  input  logic [7:0] d_in,
  output logic       inta_n,
  output logic [7:0] vec_out,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE1,
    GAP,
    PULSE2,
    HOLD,
    RECOVER
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   inta_nxt;
  logic [7:0]             vec_nxt;
  logic                   valid_nxt;
  logic                   busy_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   int_s_q;
  logic                   int_s;
  logic                   qual;

  assign int_s = sync_q[SYNC_STAGES-1];
  // Two consecutive high samples reject single-cycle glitches on INT.
  assign qual  = int_s & int_s_q;

  // Synchronizer for the asynchronous INT pin plus one-deep history for qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      int_s_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], int_in};
      int_s_q <= int_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      inta_n    <= 1'b1;
      vec_out   <= 8'h00;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      inta_n    <= inta_nxt;
      vec_out   <= vec_nxt;
      vec_valid <= valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic; once PULSE1 is entered both pulses always complete.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inta_nxt  = inta_n;
    vec_nxt   = vec_out;
    valid_nxt = vec_valid;
    case (state)
      IDLE: begin
        if (qual && ack_en) begin
          state_nxt = PULSE1;
          inta_nxt  = 1'b0;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      PULSE1: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          inta_nxt  = 1'b1;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = PULSE2;
          inta_nxt  = 1'b0;
          cnt_nxt   = PULSE_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      PULSE2: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          inta_nxt  = 1'b1;
          vec_nxt   = d_in;
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (vec_ready) begin
          state_nxt = RECOVER;
          valid_nxt = 1'b0;
          cnt_nxt   = GAP_LOAD;
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        inta_nxt  = 1'b1;
        valid_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

`ifndef SYNTHESIS
  localparam bit PARAMS_OK = (PULSE_CYCLES >= 2) && (PULSE_CYCLES <= 15) &&
                             (GAP_CYCLES >= 1) && (GAP_CYCLES <= 15) &&
                             (SYNC_STAGES >= 2) && (SYNC_STAGES <= 3);
  // Out-of-range timing parameters would overflow the 4-bit counters.
  param_range_check: assert property (@(posedge clk) PARAMS_OK)
    else $error("pic_inta_sequencer: parameter out of legal range");
`endif

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: directed scenarios followed by
// randomized traffic, all compared against a time-indexed reference model.
module tb_pic_inta_sequencer;

  localparam int P = 4;
  localparam int G = 2;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       int_in;
  logic       ack_en;
  logic [7:0] d_in;
  logic       inta_n;
  logic [7:0] vec_out;
  logic       vec_valid;
  logic       vec_ready;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;
  int falls = 0;
  int falls0;
  logic prev_inta = 1'b1;
  logic [7:0] pic_vec;

  always #5 clk = ~clk;

  pic_inta_sequencer #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .SYNC_STAGES (S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_in   (int_in),
    .ack_en   (ack_en),
    .d_in     (d_in),
    .inta_n   (inta_n),
    .vec_out  (vec_out),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .busy     (busy)
  );

  // Reference model: mode 0 idle, 1 sequencing (m_t = cycles since INTA first fell),
  // 2 holding a vector, 3 recovering. INTA waveform derived arithmetically from m_t.
  int         m_mode;
  int         m_t;
  int         m_rec;
  logic [7:0] m_vec;
  logic       m_valid;
  logic [S:0] hist;
  logic       exp_inta;
  logic       exp_busy;

  assign exp_inta = !((m_mode == 1) && ((m_t < P) || (m_t >= P + G)));
  assign exp_busy = (m_mode != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_t     <= 0;
      m_rec   <= 0;
      m_vec   <= 8'h00;
      m_valid <= 1'b0;
      hist    <= '0;
    end else begin
      hist <= {hist[S-1:0], int_in};
      case (m_mode)
        0: if (hist[S-1] && hist[S] && ack_en) begin
             m_mode <= 1;
             m_t    <= 0;
           end
        1: if (m_t == 2 * P + G - 1) begin
             m_vec   <= d_in;
             m_valid <= 1'b1;
             m_mode  <= 2;
           end else begin
             m_t <= m_t + 1;
           end
        2: if (vec_ready) begin
             m_valid <= 1'b0;
             m_mode  <= 3;
             m_rec   <= G;
           end
        default: if (m_rec <= 1) m_mode <= 0;
                 else m_rec <= m_rec - 1;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge, compare against the model, then let the PIC drive D.
  task automatic tick();
    @(negedge clk);
    check("inta_n", 32'(inta_n), 32'(exp_inta));
    check("busy", 32'(busy), 32'(exp_busy));
    check("vec_valid", 32'(vec_valid), 32'(m_valid));
    check("vec_out", 32'(vec_out), 32'(m_vec));
    if (prev_inta && !inta_n) falls++;
    prev_inta = inta_n;
    d_in = (!inta_n) ? pic_vec : 8'($urandom);
  endtask

  task automatic run_until_valid(input string tag);
    int n = 0;
    while (!vec_valid && n < 80) begin
      tick();
      n++;
    end
    check(tag, 32'(vec_valid), 32'd1);
  endtask

  task automatic accept_and_idle();
    int_in    = 1'b0;
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    int_in    = 1'b0;
    ack_en    = 1'b0;
    vec_ready = 1'b0;
    d_in      = 8'h00;
    pic_vec   = 8'h00;
    #12;
    check("rst_inta", 32'(inta_n), 32'd1);
    check("rst_vec", 32'(vec_out), 32'h00);
    check("rst_valid", 32'(vec_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic two-pulse sequence and INT-to-INTA latency
    pic_vec = 8'hA9;
    ack_en  = 1'b1;
    int_in  = 1'b1;
    falls   = 0;
    repeat (3) tick();
    check("t1_lat_high", 32'(inta_n), 32'd1);
    tick();
    check("t1_lat_low", 32'(inta_n), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    run_until_valid("t1_valid");
    check("t1_vec", 32'(vec_out), 32'hA9);
    check("t1_falls", 32'(falls), 32'd2);

    // Backpressure with INT still asserted
    repeat (10) tick();
    check("t2_vec_stable", 32'(vec_out), 32'hA9);
    check("t2_no_inta", 32'(inta_n), 32'd1);
    check("t2_falls", 32'(falls), 32'd2);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    check("t2_accept", 32'(vec_valid), 32'd0);
    repeat (2) tick();
    check("t2_recover_idle", 32'(busy), 32'd0);
    tick();
    check("t2_restart", 32'(inta_n), 32'd0);
    run_until_valid("t2_valid2");
    check("t2_falls2", 32'(falls), 32'd4);
    accept_and_idle();

    // Interrupts disabled, then enabled with INT already qualified
    ack_en = 1'b0;
    int_in = 1'b1;
    repeat (20) tick();
    check("t3_inta_idle", 32'(inta_n), 32'd1);
    check("t3_busy_idle", 32'(busy), 32'd0);
    ack_en  = 1'b1;
    pic_vec = 8'h5C;
    tick();
    check("t3_start", 32'(inta_n), 32'd0);
    ack_en = 1'b0;
    run_until_valid("t3_valid");
    check("t3_vec", 32'(vec_out), 32'h5C);
    accept_and_idle();

    // Single-cycle glitch on INT must be rejected
    ack_en = 1'b1;
    falls0 = falls;
    int_in = 1'b1;
    tick();
    int_in = 1'b0;
    repeat (10) tick();
    check("t4_falls", 32'(falls), 32'(falls0));
    check("t4_busy", 32'(busy), 32'd0);

    // INT dropped during the gap; pulse 2 still runs, spurious vector passed through
    pic_vec = 8'hAF;
    int_in  = 1'b1;
    for (int n = 0; n < 40 && !(m_mode == 1 && m_t >= P); n++) tick();
    check("t5_in_gap", 32'(inta_n), 32'd1);
    int_in = 1'b0;
    run_until_valid("t5_valid");
    check("t5_vec", 32'(vec_out), 32'hAF);
    accept_and_idle();

    // Asynchronous reset during pulse 2
    pic_vec = 8'h3C;
    int_in  = 1'b1;
    for (int n = 0; n < 40 && !(m_mode == 1 && m_t >= P + G + 1); n++) tick();
    check("t6_in_pulse2", 32'(inta_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_inta", 32'(inta_n), 32'd1);
    check("t6_rst_valid", 32'(vec_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    run_until_valid("t6_valid");
    check("t6_vec", 32'(vec_out), 32'h3C);
    accept_and_idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) int_in = ~int_in;
      if ($urandom_range(0, 15) == 0) ack_en = ~ack_en;
      vec_ready = ($urandom_range(0, 2) == 0);
      pic_vec   = 8'($urandom);
      rst_n     = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
